fetch_pc_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the main decoder in the one-tact MIPS core.
- Owns the PC, issues requests to instruction memory over a ready handshake, and holds the fetched word in an instruction register.
- Drives op_c/funct to the decoder. Consumes the decoder's beq/bne/j_c/jr_c, the ALU zero flag and the register-file jr target to form the next PC.

---
 rtl/fetch_pc_unit.sv | 205 ++++++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//
// Instruction-fetch stage in front of the main decoder. It owns the PC, fetches
// one instruction word per FETCH/EXEC pair over a same-cycle ready handshake,
// holds that word in the instruction register and works out the next PC from
// the decoder's control outputs.
//
// Optional feature macro: FETCH_DELAY_SLOT_EN
//   When it is defined, the instruction after a taken jr/j/branch (the delay
//   slot) always executes before the redirect takes effect.
//   When it is undefined, a redirect takes effect immediately.
//
// Ports
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   imem_req     fetch request (high in FETCH only, forced low while in reset)
//   imem_addr    fetch address, equal to pc
//   imem_rdata   instruction word, valid while imem_ready=1
//   imem_ready   memory accepts the request and returns data in the same cycle
//   instr        instruction register
//   op_c, funct  instr[31:26] and instr[5:0], sent to the decoder
//   instr_valid  instr is executing this cycle (EXEC state)
//   pc, pc_plus4 current PC and PC+4 (pc_plus4 is the JAL link value)
//   stall        holds the current instruction in EXEC
//   beq, bne, j_c, jr_c  decoder control outputs
//   zero         ALU equality flag
//   jr_target    rs value used by JR
//   fetch_err    sticky error flag (fetch timeout or misaligned JR)
// ---------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr,
    output logic [5:0]  op_c,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        beq,
    input  logic        bne,
    input  logic        j_c,
    input  logic        jr_c,
    input  logic        zero,
    input  logic [31:0] jr_target,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [31:0]        pc_reg, pc_next;
    logic [31:0]        instr_reg, instr_next;
    logic [CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic               fetch_err_reg, fetch_err_next;
    logic               imem_req_state;

    logic [31:0]        branch_offset;
    logic [31:0]        jump_target;
    logic [31:0]        redirect_target;
    logic               branch_taken;
    logic               redirect;
    logic               jr_misaligned;
    logic               in_delay_slot;

`ifdef FETCH_DELAY_SLOT_EN
    logic               pending_reg, pending_next;
    logic [31:0]        pending_pc_reg, pending_pc_next;
    assign in_delay_slot = pending_reg;
`else
    assign in_delay_slot = 1'b0;
`endif

    // Continuous decoder-facing outputs
    assign pc_plus4    = pc_reg + 32'd4;
    assign pc          = pc_reg;
    assign imem_addr   = pc_reg;
    assign instr       = instr_reg;
    assign op_c        = instr_reg[31:26];
    assign funct       = instr_reg[5:0];
    assign fetch_err   = fetch_err_reg;
    assign instr_valid = (state_reg == EXEC);
    // A request in flight is dropped the moment reset asserts.
    assign imem_req    = imem_req_state & rst_n;

    // Next-PC candidates
    assign branch_offset = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], instr_reg[25:0], 2'b00};
    assign branch_taken  = (beq & zero) | (bne & ~zero);
    assign redirect      = jr_c | j_c | branch_taken;
    assign jr_misaligned = jr_c & (jr_target[1:0] != 2'b00);

    // Priority jr > j > taken branch
    always_comb begin
        redirect_target = pc_plus4 + branch_offset;
        if (jr_c) begin
            redirect_target = jr_target;
        end else if (j_c) begin
            redirect_target = jump_target;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        instr_next      = instr_reg;
        wait_cnt_next   = wait_cnt_reg;
        fetch_err_next  = fetch_err_reg;
        imem_req_state  = 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
        pending_next    = pending_reg;
        pending_pc_next = pending_pc_reg;
`endif
        case (state_reg)
            FETCH: begin
                imem_req_state = 1'b1;
                if (imem_ready) begin
                    instr_next    = imem_rdata;
                    wait_cnt_next = '0;
                    state_next    = EXEC;
                end else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th cycle without ready.
                    fetch_err_next = 1'b1;
                    wait_cnt_next  = '0;
                    state_next     = HALT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            EXEC: begin
                if (!stall) begin
                    if (in_delay_slot) begin
                        // Delay-slot instruction: its own controls are
                        // ignored and the stored redirect is applied.
`ifdef FETCH_DELAY_SLOT_EN
                        pc_next      = pending_pc_reg;
                        pending_next = 1'b0;
`endif
                        state_next = FETCH;
                    end else if (jr_misaligned) begin
                        fetch_err_next = 1'b1;
                        state_next     = HALT;
                    end else begin
                        if (redirect) begin
`ifdef FETCH_DELAY_SLOT_EN
                            pending_next    = 1'b1;
                            pending_pc_next = redirect_target;
                            pc_next         = pc_plus4;
`else
                            pc_next = redirect_target;
`endif
                        end else begin
                            pc_next = pc_plus4;
                        end
                        state_next = FETCH;
                    end
                end
            end
            HALT: begin
                // Frozen until reset.
            end
            default: begin
                state_next = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= FETCH;
            pc_reg         <= RESET_PC;
            instr_reg      <= 32'd0;
            wait_cnt_reg   <= '0;
            fetch_err_reg  <= 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
            pending_reg    <= 1'b0;
            pending_pc_reg <= 32'd0;
`endif
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            instr_reg      <= instr_next;
            wait_cnt_reg   <= wait_cnt_next;
            fetch_err_reg  <= fetch_err_next;
`ifdef FETCH_DELAY_SLOT_EN
            pending_reg    <= pending_next;
            pending_pc_reg <= pending_pc_next;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_ready = 1'b0;
    logic [31:0] instr;
    logic [5:0]  op_c;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        stall = 1'b0;
    logic        beq = 1'b0;
    logic        bne = 1'b0;
    logic        j_c = 1'b0;
    logic        jr_c = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic        fetch_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 = waiting for a word, 1 = executing, 2 = halted
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    int          m_wait;      // not-ready cycles seen in the current fetch
    bit          m_err;
    bit          m_pend;
    logic [31:0] m_pend_tgt;
    bit          m_in_reset;

    logic [31:0] prog [logic [31:0]];

    fetch_pc_unit #(
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .instr       (instr),
        .op_c        (op_c),
        .funct       (funct),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .stall       (stall),
        .beq         (beq),
        .bne         (bne),
        .j_c         (j_c),
        .jr_c        (jr_c),
        .zero        (zero),
        .jr_target   (jr_target),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (prog.exists(a)) return prog[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic model_reset();
        m_phase    = 0;
        m_pc       = RESET_PC;
        m_instr    = 32'd0;
        m_wait     = 0;
        m_err      = 1'b0;
        m_pend     = 1'b0;
        m_pend_tgt = 32'd0;
        m_in_reset = 1'b1;
    endtask

    task automatic model_cycle(input bit rdy, input bit stl, input bit b_eq, input bit b_ne,
                               input bit jc, input bit jrc, input bit z,
                               input logic [31:0] jt, input logic [31:0] word);
        logic [31:0] seq;
        logic [31:0] tgt;
        logic [31:0] old_pc;
        int          off;
        bit          take;
        case (m_phase)
            0: begin
                if (rdy) begin
                    m_instr = word;
                    m_wait  = 0;
                    m_phase = 1;
                end else begin
                    m_wait++;
                    if (m_wait >= TIMEOUT) begin
                        m_err   = 1'b1;
                        m_phase = 2;
                    end
                end
            end
            1: begin
                if (!stl) begin
                    old_pc = m_pc;
                    seq    = m_pc + 32'd4;
                    off    = int'($signed(m_instr[15:0])) * 4;
                    take   = 1'b1;
                    tgt    = seq;
                    if (jrc)                               tgt = jt;
                    else if (jc)                           tgt = (seq & 32'hF000_0000) + ((m_instr & 32'h03FF_FFFF) * 4);
                    else if ((b_eq && z) || (b_ne && !z))  tgt = seq + 32'(off);
                    else                                   take = 1'b0;
                    if (m_pend) begin
                        m_pc    = m_pend_tgt;
                        m_pend  = 1'b0;
                        m_phase = 0;
                    end else if (jrc && (jt % 4) != 0) begin
                        m_err   = 1'b1;
                        m_phase = 2;
                    end else begin
                        if (take) begin
`ifdef FETCH_DELAY_SLOT_EN
                            m_pend     = 1'b1;
                            m_pend_tgt = tgt;
                            m_pc       = seq;
`else
                            m_pc = tgt;
`endif
                        end else begin
                            m_pc = seq;
                        end
                        m_phase = 0;
                    end
                    $display("retire pc=%08h instr=%08h next=%08h err=%0d", old_pc, m_instr, m_pc, m_err);
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        check("imem_req",    imem_req,    (m_phase == 0 && !m_in_reset) ? 32'd1 : 32'd0);
        check("imem_addr",   imem_addr,   m_pc);
        check("pc",          pc,          m_pc);
        check("pc_plus4",    pc_plus4,    m_pc + 32'd4);
        check("instr",       instr,       m_instr);
        check("op_c",        op_c,        m_instr >> 26);
        check("funct",       funct,       m_instr & 32'h3F);
        check("instr_valid", instr_valid, (m_phase == 1) ? 32'd1 : 32'd0);
        check("fetch_err",   fetch_err,   m_err ? 32'd1 : 32'd0);
    endtask

    task automatic do_reset(input bit at_start);
        rst_n = 1'b0;
        model_reset();
        #1;
        if (!at_start) compare_all();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst_n      = 1'b1;
        m_in_reset = 1'b0;
    endtask

    task automatic step(input bit rdy, input bit stl, input bit b_eq, input bit b_ne,
                        input bit jc, input bit jrc, input bit z, input logic [31:0] jt);
        imem_ready = rdy;
        stall      = stl;
        beq        = b_eq;
        bne        = b_ne;
        j_c        = jc;
        jr_c       = jrc;
        zero       = z;
        jr_target  = jt;
        imem_rdata = word_at(m_pc);
        model_cycle(rdy, stl, b_eq, b_ne, jc, jrc, z, jt, imem_rdata);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_step(input bit rdy);
        step(rdy, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    // Fetch one word, then execute it with the given controls.
    task automatic exec_one(input bit b_eq, input bit b_ne, input bit jc, input bit jrc,
                            input bit z, input logic [31:0] jt);
        idle_step(1'b1);
        step(1'b1, 1'b0, b_eq, b_ne, jc, jrc, z, jt);
    endtask

    // In delay-slot builds the next address is the slot; run it plainly.
    task automatic ds_slot(input logic [31:0] slot_addr);
`ifdef FETCH_DELAY_SLOT_EN
        check("ds_slot_addr", imem_addr, slot_addr);
        exec_one(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
`else
        if (slot_addr == 32'hFFFF_FFFF) $display("unreachable slot");
`endif
    endtask

    task automatic run_to(input logic [31:0] addr);
        for (int i = 0; i < 400; i++) begin
            if (m_phase == 0 && m_pc == addr) break;
            idle_step(1'b1);
        end
        check("run_to", imem_addr, addr);
    endtask

    initial begin
        int halt_cycles;
        logic [31:0] r;
        logic [31:0] jt;

        prog[32'h10] = 32'h1000_FFFE;   // beq with offset -2
        prog[32'h20] = 32'h0800_0040;   // j to 0x100
        prog[32'h40] = 32'h0800_0100;   // j to 0x400

        // Reset state and straight-line fetch 0, 4, 8
        do_reset(1'b1);
        check("rst_addr",  imem_addr,   32'h0);
        check("rst_valid", instr_valid, 32'd0);
        idle_step(1'b1);
        check("seq_valid_exec", instr_valid, 32'd1);
        idle_step(1'b1);
        check("seq_addr4", imem_addr, 32'h4);
        check("seq_valid_fetch", instr_valid, 32'd0);
        idle_step(1'b1);
        idle_step(1'b1);
        check("seq_addr8", imem_addr, 32'h8);

        // Branch taken and not taken at 0x10
        do_reset(1'b0);
        run_to(32'h10);
        exec_one(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        ds_slot(32'h14);
        check("beq_taken", imem_addr, 32'h0C);
        do_reset(1'b0);
        run_to(32'h10);
        exec_one(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("beq_not_taken", imem_addr, 32'h14);

        // j at 0x40, then jr wins over j
        do_reset(1'b0);
        run_to(32'h40);
        exec_one(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        ds_slot(32'h44);
        check("j_target", imem_addr, 32'h400);
        exec_one(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80);
        ds_slot(32'h404);
        check("jr_over_j", imem_addr, 32'h80);

        // Fetch timeout
        do_reset(1'b0);
        repeat (TIMEOUT - 1) idle_step(1'b0);
        check("timeout_not_yet", fetch_err, 32'd0);
        idle_step(1'b0);
        check("timeout_err", fetch_err, 32'd1);
        check("timeout_req", imem_req, 32'd0);
        repeat (4) idle_step(1'b1);
        check("halt_sticky", fetch_err, 32'd1);
        check("halt_pc", pc, RESET_PC);
        do_reset(1'b0);
        check("err_cleared", fetch_err, 32'd0);

        // Misaligned jr
        exec_one(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h83);
        check("misalign_err", fetch_err, 32'd1);
        repeat (3) idle_step(1'b1);
        check("misalign_pc", pc, 32'h0);

        // PC wrap at the top of the address space
        do_reset(1'b0);
        exec_one(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
        ds_slot(32'h4);
        check("wrap_top", imem_addr, 32'hFFFF_FFFC);
        exec_one(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("wrap_zero", imem_addr, 32'h0);
        check("wrap_no_err", fetch_err, 32'd0);

        // Stall holds the instruction in EXEC
        do_reset(1'b0);
        idle_step(1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
            check("stall_valid", instr_valid, 32'd1);
            check("stall_pc", pc, 32'h0);
        end
        idle_step(1'b1);
        check("stall_release", imem_addr, 32'h4);

        // j at 0x20 to 0x100
        do_reset(1'b0);
        run_to(32'h20);
        exec_one(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        ds_slot(32'h24);
        check("j_0x100", imem_addr, 32'h100);

        // Randomized traffic against the model
        do_reset(1'b0);
        halt_cycles = 0;
        for (int i = 0; i < 800; i++) begin
            if (m_phase == 2) halt_cycles++;
            if (halt_cycles > 3) begin
                do_reset(1'b0);
                halt_cycles = 0;
            end
            r  = $urandom();
            jt = $urandom() & 32'h0000_FFFC;
            if ((r % 4) == 0) jt = jt | ((r >> 20) & 32'h3);
            step((r % 4) != 1, ((r >> 2) % 4) == 0,
                 ((r >> 4) % 6) == 0, ((r >> 7) % 6) == 0,
                 ((r >> 10) % 8) == 0, ((r >> 13) % 8) == 0,
                 ((r >> 16) % 2) == 0, jt);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
